// File: rtl/buffer_etapa_elastico_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit layout, NOP value and
// the fill status used by the elastic inter-stage buffers.
package pipeline_pkg;

    localparam int unsigned CTRL_W = 11;

    localparam int unsigned CTRL_JUMP      = 0;
    localparam int unsigned CTRL_MEMTOREG  = 1;
    localparam int unsigned CTRL_REGWRITE  = 2;
    localparam int unsigned CTRL_MEMREAD   = 3;
    localparam int unsigned CTRL_MEMWRITE  = 4;
    localparam int unsigned CTRL_BRANCH    = 5;
    localparam int unsigned CTRL_ALUSRC    = 6;
    localparam int unsigned CTRL_ALUOP_LSB = 7;
    localparam int unsigned CTRL_ALUOP_MSB = 9;
    localparam int unsigned CTRL_REGDST    = 10;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // A bubble is an all-zero control bundle: no write, no memory access, no branch.
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fill_e;

endpackage

// File: rtl/buffer_etapa_elastico_if.sv
// Handshake bundle between two pipeline stages: upstream push side, downstream
// pop side and the squash request.
interface buffer_etapa_elastico_if
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = pipeline_pkg::CTRL_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

endinterface

// File: rtl/buffer_etapa_elastico_contador_sat.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module contador_sat #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/buffer_etapa_elastico.sv
// Elastic inter-stage pipeline buffer: DEPTH-entry circular store with
// valid/ready handshake, synchronous squash and a saturating stall counter.
module buffer_etapa_elastico
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = pipeline_pkg::CTRL_W,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    buffer_etapa_elastico_if.slave     bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    if (DEPTH < 2) begin : g_depth_check
        $error("buffer_etapa_elastico: DEPTH must be at least 2");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head_ent;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    fill_e            fill;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;
    logic             stall_en;

    // Explicit wrap compare so non-power-of-two depths cycle 0..DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        fill = ST_PARTIAL;
        if (count_q == '0) begin
            fill = ST_EMPTY;
        end else if (count_q == FULL_CNT) begin
            fill = ST_FULL;
        end
    end

    // Ready is built from registered fill level only, so a pop cannot free a
    // slot for a push in the same cycle.
    assign in_ready_w  = !bus.flush && (fill != ST_FULL);
    assign out_valid_w = !bus.flush && (fill != ST_EMPTY);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;
    assign stall_en    = bus.in_valid && !in_ready_w && !bus.flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + OCC_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail_q] <= '{data: bus.in_data, ctrl: bus.in_ctrl};
        end
    end

    assign head_ent = mem[head_q];

    // Non-valid cycles present a bubble so downstream never sees stale control.
    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.out_data  = out_valid_w ? head_ent.data : '0;
        bus.out_ctrl  = out_valid_w ? head_ent.ctrl : CTRL_W'(CTRL_NOP);
    end

    assign occupancy = count_q;

    contador_sat #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .en_i   (stall_en),
        .cnt_o  (stall_cnt)
    );

endmodule

// File: tb/tb_buffer_etapa_elastico.sv
// Scoreboard bench for two elastic buffers (DEPTH=2/CNT_W=16 and DEPTH=3/CNT_W=4)
// checked every cycle against a queue-based reference model.
module tb_buffer_etapa_elastico;
    import pipeline_pkg::*;

    localparam int unsigned DW = 32;
    localparam int SAT_CYCLES = 25;

    typedef logic [DW+CTRL_W-1:0] ent_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    buffer_etapa_elastico_if #(.DATA_W(DW), .CTRL_W(CTRL_W)) bus_a ();
    buffer_etapa_elastico_if #(.DATA_W(DW), .CTRL_W(CTRL_W)) bus_b ();

    logic [1:0]  occ_a;
    logic [1:0]  occ_b;
    logic [15:0] scnt_a;
    logic [3:0]  scnt_b;

    buffer_etapa_elastico #(.DATA_W(DW), .CTRL_W(CTRL_W), .DEPTH(2), .CNT_W(16)) dut_a (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus_a),
        .occupancy (occ_a),
        .stall_cnt (scnt_a)
    );

    buffer_etapa_elastico #(.DATA_W(DW), .CTRL_W(CTRL_W), .DEPTH(3), .CNT_W(4)) dut_b (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus_b),
        .occupancy (occ_b),
        .stall_cnt (scnt_b)
    );

    // Reference model: per-instance FIFO of held entries plus a stall tally.
    ent_t        mq [2][$];
    int unsigned m_stall [2];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int          ncyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input int id, input logic iv, input logic fl, input logic ordy,
                               input logic [DW-1:0] din, input logic [CTRL_W-1:0] cin,
                               input logic irdy, input logic ov,
                               input logic [DW-1:0] dout, input logic [CTRL_W-1:0] cout,
                               input int unsigned occ, input int unsigned sc);
        int          depth;
        int unsigned smax;
        string       tag;
        logic        e_rdy;
        logic        e_val;
        ent_t        head;
        depth = (id == 0) ? 2 : 3;
        smax  = (id == 0) ? 32'd65535 : 32'd15;
        tag   = (id == 0) ? "A" : "B";
        if (!RST_N) begin
            mq[id].delete();
            m_stall[id] = 0;
        end
        e_rdy = !fl && (mq[id].size() < depth);
        e_val = !fl && (mq[id].size() != 0);
        head  = (mq[id].size() != 0) ? mq[id][0] : '0;
        chk($sformatf("%s.in_ready", tag), 64'(irdy), 64'(e_rdy));
        chk($sformatf("%s.out_valid", tag), 64'(ov), 64'(e_val));
        chk($sformatf("%s.occupancy", tag), 64'(occ), 64'(mq[id].size()));
        chk($sformatf("%s.stall_cnt", tag), 64'(sc), 64'(m_stall[id]));
        chk($sformatf("%s.out_ctrl", tag), 64'(cout), e_val ? 64'(head[CTRL_W-1:0]) : 64'(0));
        if (e_val || mq[id].size() == 0) begin
            chk($sformatf("%s.out_data", tag), 64'(dout), e_val ? 64'(head[DW+CTRL_W-1:CTRL_W]) : 64'(0));
        end
        if (RST_N) begin
            if (fl) begin
                mq[id].delete();
            end else begin
                if (e_val && ordy) void'(mq[id].pop_front());
                if (iv && e_rdy) mq[id].push_back({din, cin});
                if (iv && !e_rdy && m_stall[id] < smax) m_stall[id]++;
            end
        end
    endtask

    always @(negedge CLK) begin
        model_cycle(0, bus_a.in_valid, bus_a.flush, bus_a.out_ready, bus_a.in_data, bus_a.in_ctrl,
                    bus_a.in_ready, bus_a.out_valid, bus_a.out_data, bus_a.out_ctrl,
                    32'(occ_a), 32'(scnt_a));
        model_cycle(1, bus_b.in_valid, bus_b.flush, bus_b.out_ready, bus_b.in_data, bus_b.in_ctrl,
                    bus_b.in_ready, bus_b.out_valid, bus_b.out_data, bus_b.out_ctrl,
                    32'(occ_b), 32'(scnt_b));
    end

    task automatic drive_a(input logic iv, input logic [DW-1:0] d, input logic [CTRL_W-1:0] c,
                           input logic fl, input logic ordy);
        bus_a.in_valid  = iv;
        bus_a.in_data   = d;
        bus_a.in_ctrl   = c;
        bus_a.flush     = fl;
        bus_a.out_ready = ordy;
    endtask

    // B saturates its stall counter first, then runs random traffic with flushes.
    task automatic drive_b();
        bus_b.in_data = $urandom;
        bus_b.in_ctrl = CTRL_W'($urandom);
        if (ncyc < SAT_CYCLES) begin
            bus_b.in_valid  = 1'b1;
            bus_b.out_ready = 1'b0;
            bus_b.flush     = 1'b0;
        end else begin
            bus_b.in_valid  = ($urandom_range(0, 3) != 0);
            bus_b.out_ready = ($urandom_range(0, 1) != 0);
            bus_b.flush     = ($urandom_range(0, 24) == 0);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        if (RST_N) ncyc++;
        drive_b();
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.in_ctrl   = '0;
        bus_b.flush     = 1'b0;
        bus_b.out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle_a(2);

        // Streaming with downstream always ready.
        cyc(); drive_a(1'b1, 32'h0000_0004, 11'h001, 1'b0, 1'b1);
        cyc(); drive_a(1'b1, 32'h0000_0008, 11'h002, 1'b0, 1'b1);
        cyc(); drive_a(1'b1, 32'h0000_000C, 11'h004, 1'b0, 1'b1);
        idle_a(2);

        // Fill with downstream stalled, third entry blocked, then drain.
        cyc(); drive_a(1'b1, 32'h100, 11'h010, 1'b0, 1'b0);
        cyc(); drive_a(1'b1, 32'h200, 11'h020, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_a(1'b1, 32'h300, 11'h040, 1'b0, 1'b0);
        end
        cyc(); drive_a(1'b1, 32'h300, 11'h040, 1'b0, 1'b1);
        cyc(); drive_a(1'b1, 32'h300, 11'h040, 1'b0, 1'b1);
        idle_a(3);

        // Squash two held entries; the entry offered during flush is dropped.
        cyc(); drive_a(1'b1, 32'hA1, 11'h7FF, 1'b0, 1'b0);
        cyc(); drive_a(1'b1, 32'hA2, 11'h7FF, 1'b0, 1'b0);
        cyc(); drive_a(1'b1, 32'hDEAD, 11'h7FF, 1'b1, 1'b0);
        idle_a(3);

        // Reset with two entries held.
        cyc(); drive_a(1'b1, 32'hB1, 11'h003, 1'b0, 1'b0);
        cyc(); drive_a(1'b1, 32'hB2, 11'h005, 1'b0, 1'b0);
        cyc(); drive_a(1'b0, '0, '0, 1'b0, 1'b0);
        RST_N = 1'b0;
        cyc();
        cyc();
        RST_N = 1'b1;
        idle_a(2);

        // Random traffic on A with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cyc();
            drive_a(($urandom_range(0, 3) != 0), $urandom, CTRL_W'($urandom),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
        end
        idle_a(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
